// File: rtl/par_out_arbiter.sv
// Round-robin arbiter sharing the parallel output register between two write requesters.
// Optional ack timeout with sticky error flag when PAR_OUT_TIMEOUT_EN is defined.
module par_out_arbiter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter logic [ADDR_W-1:0] OUT_ADDR = {ADDR_W{1'b1}}
`ifdef PAR_OUT_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] data0_i,
  output logic              gnt0_o,
  input  logic              req1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] data1_i,
  output logic              gnt1_o,
  output logic              port_en_o,
  output logic [ADDR_W-1:0] port_addr_o,
  output logic [DATA_W-1:0] port_data_o,
  output logic              dev_strobe_o,
  input  logic              dev_ack_i,
  output logic              busy_o,
  output logic              miss_o,
  output logic              err_o
);

  typedef enum logic [1:0] {StIdle, StWrite, StStrobe} state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              port_en_q, port_en_d;
  logic [ADDR_W-1:0] port_addr_q, port_addr_d;
  logic [DATA_W-1:0] port_data_q, port_data_d;
  logic              strobe_q, strobe_d;
  logic              miss_q, miss_d;

  logic              win;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // last_q holds the index of the previous winner; a tie goes to the other requester.
  assign win      = (req0_i & req1_i) ? ~last_q : req1_i;
  assign sel_addr = win ? addr1_i : addr0_i;
  assign sel_data = win ? data1_i : data0_i;

`ifdef PAR_OUT_TIMEOUT_EN
  localparam logic [7:0] TimeoutLim = TIMEOUT_CYCLES[7:0];
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    port_en_d   = 1'b0;
    port_addr_d = port_addr_q;
    port_data_d = port_data_q;
    strobe_d    = 1'b0;
    miss_d      = 1'b0;
`ifdef PAR_OUT_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req0_i | req1_i) begin
          last_d      = win;
          gnt0_d      = ~win;
          gnt1_d      = win;
          port_addr_d = sel_addr;
          port_data_d = sel_data;
          if (sel_addr == OUT_ADDR) begin
            port_en_d = 1'b1;
            state_d   = StWrite;
          end else begin
            miss_d = 1'b1;
          end
        end
      end
      StWrite: begin
        strobe_d = 1'b1;
        state_d  = StStrobe;
`ifdef PAR_OUT_TIMEOUT_EN
        cnt_d    = 8'd0;
`endif
      end
      StStrobe: begin
        if (dev_ack_i) begin
          state_d = StIdle;
        end else begin
          strobe_d = 1'b1;
`ifdef PAR_OUT_TIMEOUT_EN
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TimeoutLim) begin
            strobe_d = 1'b0;
            err_d    = 1'b1;
            state_d  = StIdle;
          end
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      port_en_q   <= 1'b0;
      port_addr_q <= '0;
      port_data_q <= '0;
      strobe_q    <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      port_en_q   <= port_en_d;
      port_addr_q <= port_addr_d;
      port_data_q <= port_data_d;
      strobe_q    <= strobe_d;
      miss_q      <= miss_d;
    end
  end

`ifdef PAR_OUT_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign gnt0_o       = gnt0_q;
  assign gnt1_o       = gnt1_q;
  assign port_en_o    = port_en_q;
  assign port_addr_o  = port_addr_q;
  assign port_data_o  = port_data_q;
  assign dev_strobe_o = strobe_q;
  assign miss_o       = miss_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_par_out_arbiter.sv
// Scoreboard bench for par_out_arbiter: expected grants are queued on request and
// checked when a grant pulse appears.
module tb_par_out_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [7:0] addr0, addr1, data0, data1;
  logic       gnt0, gnt1, port_en, dev_strobe, dev_ack, busy, miss, err;
  logic [7:0] port_addr, port_data;

  always #5 clk = ~clk;

  par_out_arbiter #(
    .DATA_W        (8),
    .ADDR_W        (8),
    .OUT_ADDR      (8'hFF)
`ifdef PAR_OUT_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req0_i      (req0),
    .addr0_i     (addr0),
    .data0_i     (data0),
    .gnt0_o      (gnt0),
    .req1_i      (req1),
    .addr1_i     (addr1),
    .data1_i     (data1),
    .gnt1_o      (gnt1),
    .port_en_o   (port_en),
    .port_addr_o (port_addr),
    .port_data_o (port_data),
    .dev_strobe_o(dev_strobe),
    .dev_ack_i   (dev_ack),
    .busy_o      (busy),
    .miss_o      (miss),
    .err_o       (err)
  );

  typedef struct packed {
    logic       id;
    logic       hit;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic expect_wr(input logic id, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    e.id   = id;
    e.hit  = (a == 8'hFF);
    e.addr = a;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic id, input logic [7:0] a, input logic [7:0] d);
    if (!id) begin
      req0 = 1'b1; addr0 = a; data0 = d;
    end else begin
      req1 = 1'b1; addr1 = a; data1 = d;
    end
    expect_wr(id, a, d);
  endtask

  // One cycle: sample at the falling edge, score any grant, requesters drop on grant.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (gnt0 | gnt1) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_gnt", 32'(1), 32'(0));
      end else begin
        e = sb_q.pop_front();
        check("sb_gnt_onehot", 32'(gnt0 & gnt1), 32'(0));
        check("sb_gnt_id", 32'(gnt1), 32'(e.id));
        check("sb_port_en", 32'(port_en), 32'(e.hit));
        check("sb_miss", 32'(miss), 32'(!e.hit));
        check("sb_port_addr", 32'(port_addr), 32'(e.addr));
        check("sb_port_data", 32'(port_data), 32'(e.data));
      end
    end
    if (gnt0) req0 = 1'b0;
    if (gnt1) req1 = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int i = 0;
    do begin
      step();
      i++;
    end while ((req0 || req1 || busy) && i < bound);
    check("drain_done", 32'(req0 | req1 | busy), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; dev_ack = 1'b0;
    addr0 = 8'h00; addr1 = 8'h00; data0 = 8'h00; data1 = 8'h00;
    step();
    step();
    check("rst_outputs", 32'({gnt0, gnt1, port_en, dev_strobe, miss, err, busy}), 32'(0));
    check("rst_port", 32'({port_addr, port_data}), 32'(0));
    rst = 1'b0;

    // Single accepted write, ack raised two cycles into the strobe.
    drive(1'b0, 8'hFF, 8'h5A);
    step();
    check("lat_busy_n1", 32'(busy), 32'(1));
    check("lat_strobe_n1", 32'(dev_strobe), 32'(0));
    step();
    check("lat_strobe_n2", 32'({dev_strobe, port_en, gnt0}), 32'(3'b100));
    step();
    check("lat_strobe_n3", 32'(dev_strobe), 32'(1));
    step();
    check("lat_strobe_n4", 32'(dev_strobe), 32'(1));
    dev_ack = 1'b1;
    step();
    check("lat_done", 32'({dev_strobe, busy}), 32'(0));
    dev_ack = 1'b0;

    // Ties alternate: last winner was req0, but a tie after reset and req0 must
    // still follow round-robin order. Here req1 wins since req0 was served last.
    dev_ack = 1'b1;
    drive(1'b1, 8'hFF, 8'h22);
    drive(1'b0, 8'hFF, 8'h11);
    sb_q.delete();
    expect_wr(1'b1, 8'hFF, 8'h22);
    expect_wr(1'b0, 8'hFF, 8'h11);
    wait_drain(30);
    check("tie1_sb_empty", 32'(sb_q.size()), 32'(0));
    drive(1'b0, 8'hFF, 8'h44);
    drive(1'b1, 8'hFF, 8'h55);
    sb_q.delete();
    expect_wr(1'b1, 8'hFF, 8'h55);
    expect_wr(1'b0, 8'hFF, 8'h44);
    wait_drain(30);
    check("tie2_sb_empty", 32'(sb_q.size()), 32'(0));
    dev_ack = 1'b0;

    // Miss: non-matching address consumes the grant without a write.
    drive(1'b1, 8'h10, 8'h33);
    step();
    check("miss_busy", 32'(busy), 32'(0));
    step();
    check("miss_after", 32'({miss, dev_strobe, busy, gnt1, port_en}), 32'(0));

    // Ack held high: 3-cycle transfer, stray ack in idle is harmless.
    dev_ack = 1'b1;
    drive(1'b0, 8'hFF, 8'h77);
    step();
    check("ackhi_busy", 32'(busy), 32'(1));
    step();
    check("ackhi_strobe", 32'(dev_strobe), 32'(1));
    step();
    check("ackhi_done", 32'({dev_strobe, busy}), 32'(0));
    repeat (3) step();
    check("ackhi_idle", 32'({dev_strobe, busy, gnt0, gnt1, port_en}), 32'(0));
    check("hold_port_data", 32'(port_data), 32'(8'h77));
    dev_ack = 1'b0;

    // Reset during strobe; last_grant must return to 1 so req0 wins the tie after.
    drive(1'b0, 8'hFF, 8'h66);
    step();
    step();
    check("rst_mid_strobe_pre", 32'(dev_strobe), 32'(1));
    rst = 1'b1;
    req1 = 1'b1; addr1 = 8'hFF; data1 = 8'h99;
    step();
    check("rst_mid_outputs", 32'({dev_strobe, busy, gnt1, gnt0}), 32'(0));
    check("rst_mid_port", 32'(port_data), 32'(0));
    rst = 1'b0;
    drive(1'b0, 8'hFF, 8'hAA);
    expect_wr(1'b1, 8'hFF, 8'h99);
    dev_ack = 1'b1;
    wait_drain(30);
    check("rst_mid_sb_empty", 32'(sb_q.size()), 32'(0));
    dev_ack = 1'b0;

`ifdef PAR_OUT_TIMEOUT_EN
    drive(1'b0, 8'hFF, 8'hC3);
    step();
    step();
    n = 0;
    while (dev_strobe && n < 20) begin
      n++;
      step();
    end
    check("to_strobe_len", 32'(n), 32'(4));
    check("to_err_set", 32'({err, busy}), 32'(2'b10));
    dev_ack = 1'b1;
    drive(1'b0, 8'hFF, 8'hD4);
    wait_drain(10);
    check("to_err_sticky", 32'(err), 32'(1));
    dev_ack = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("to_err_cleared", 32'(err), 32'(0));
`else
    drive(1'b0, 8'hFF, 8'hC3);
    step();
    step();
    n = 0;
    repeat (300) begin
      step();
      if (dev_strobe) n++;
    end
    check("noto_strobe_held", 32'(n), 32'(300));
    check("noto_err", 32'(err), 32'(0));
    dev_ack = 1'b1;
    step();
    check("noto_done", 32'({dev_strobe, busy}), 32'(0));
    dev_ack = 1'b0;
`endif

    check("final_sb_empty", 32'(sb_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
